// File: rtl/sha_ctrl_multiblk_pkg.sv
// Shared types and constants for the multi-block SHA control unit.
package sha_ctrl_multiblk_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    ROUND    = 3'd2,
    UPDATE   = 3'd3,
    WAIT_BLK = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam int SHA256_ROUNDS = 64;
  localparam int SHA512_ROUNDS = 80;

endpackage

// File: rtl/sha_ctrl_multiblk_round_cnt.sv
// Round index counter: clear has priority over enable, tc flags the final round.
module sha_ctrl_multiblk_round_cnt #(
  parameter int ROUNDS = 64,
  parameter int CNT_W  = $clog2(ROUNDS)
) (
  input  logic             usr_clk,
  input  logic             usr_reset_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

  // NOTE: async active-low reset in the sensitivity list; state updates use <= so every flop samples pre-edge values.
  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/sha_ctrl_multiblk.sv
// SHA block sequencer: loads each block, runs ROUNDS rounds, updates the hash and
// chains blocks until the last one, then holds the digest until acknowledged.
module sha_ctrl_multiblk
  import sha_ctrl_multiblk_pkg::*;
#(
  parameter int ROUNDS    = SHA256_ROUNDS,
  parameter int CNT_W     = $clog2(ROUNDS),
  parameter int BLK_CNT_W = 8
) (
  input  logic                 usr_clk,
  input  logic                 usr_reset_n,
  input  logic                 i_start,
  input  logic                 i_last,
  input  logic                 i_abort,
  input  logic                 i_ack,
  output logic                 o_ready,
  output logic                 o_load_blk,
  output logic                 o_load_iv,
  output logic                 o_cnt_en,
  output logic [CNT_W-1:0]     o_round,
  output logic                 o_upd_hash,
  output logic                 o_valid,
  output logic                 o_sel_out,
  output logic [BLK_CNT_W-1:0] o_blk_cnt
);

  state_t               state;
  state_t               state_nxt;
  logic                 last_q;
  logic                 first_q;
  logic [BLK_CNT_W-1:0] blk_cnt;
  logic                 cnt_clr;
  logic                 cnt_en;
  logic                 cnt_tc;

  sha_ctrl_multiblk_round_cnt #(
    .ROUNDS (ROUNDS),
    .CNT_W  (CNT_W)
  ) u_round_cnt (
    .usr_clk     (usr_clk),
    .usr_reset_n (usr_reset_n),
    .clr         (cnt_clr),
    .en          (cnt_en),
    .cnt         (o_round),
    .tc          (cnt_tc)
  );

  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    cnt_clr    = 1'b1;
    cnt_en     = 1'b0;
    o_ready    = 1'b0;
    o_load_blk = 1'b0;
    o_load_iv  = 1'b0;
    o_cnt_en   = 1'b0;
    o_upd_hash = 1'b0;
    o_valid    = 1'b0;
    o_sel_out  = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_start) state_nxt = LOAD;
      end
      LOAD: begin
        o_load_blk = 1'b1;
        o_load_iv  = first_q;
        state_nxt  = ROUND;
      end
      ROUND: begin
        o_cnt_en = 1'b1;
        cnt_en   = 1'b1;
        cnt_clr  = cnt_tc;
        if (cnt_tc) state_nxt = UPDATE;
      end
      UPDATE: begin
        o_upd_hash = 1'b1;
        state_nxt  = last_q ? DONE : WAIT_BLK;
      end
      WAIT_BLK: begin
        o_ready = 1'b1;
        if (i_start) state_nxt = LOAD;
      end
      DONE: begin
        o_valid   = 1'b1;
        o_sel_out = 1'b1;
        if (i_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort overrides whatever the state decode chose, including a same-cycle start.
    if (i_abort) begin
      state_nxt = IDLE;
      cnt_clr   = 1'b1;
    end
  end

  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      last_q  <= 1'b0;
      first_q <= 1'b1;
      blk_cnt <= '0;
    end else if (i_abort) begin
      last_q  <= 1'b0;
      first_q <= 1'b1;
      blk_cnt <= '0;
    end else begin
      if (state == IDLE && i_start) begin
        last_q  <= i_last;
        first_q <= 1'b1;
        blk_cnt <= '0;
      end else if (state == WAIT_BLK && i_start) begin
        last_q  <= i_last;
        first_q <= 1'b0;
      end
      if (state == UPDATE && blk_cnt != '1) begin
        blk_cnt <= blk_cnt + BLK_CNT_W'(1);
      end
    end
  end

  assign o_blk_cnt = blk_cnt;

endmodule
